yarp_instr_fetch: RTL

YARP_INSTR_FETCH -- requirements
Module: yarp_instr_fetch

---
 rtl/yarp_instr_fetch.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/yarp_instr_fetch.sv
// -----------------------------------------------------------------------------
// yarp_instr_fetch
//
// Instruction fetch front end. Issues word-sequential requests to the
// instruction memory, tags each response with the PC it was fetched from and
// holds the pair in a small FIFO until the core takes it. A redirect (branch,
// jump, trap) reloads the fetch PC and flushes everything. Responses still in
// flight for the old path are absorbed in DRAIN so that they never reach the
// core.
//
// Optional feature: define YARP_IFETCH_ERR_EN to carry a per-entry bus error
// bit (mem_err_i -> instr_err_o). After an errored response, fetching stops
// until the next redirect. Without the macro the error ports do not exist.
//
// Parameters
//   XLEN      : address/data width
//   DEPTH     : fetch buffer entries (power of 2, 2..16)
//   MAX_OUTST : max requests granted but not yet answered (1..DEPTH)
//   RESET_PC  : first fetch address after reset
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   redirect_valid_i/pc_i load a new fetch PC and flush
//   mem_req_o/addr_o      request to instruction memory, held until mem_gnt_i
//   mem_gnt_i             request accepted this cycle
//   mem_rvalid_i/rdata_i  read data, returned in request order
//   mem_err_i             bus error qualifying rvalid (ERR_EN only)
//   instr_valid_o/o/pc_o  buffer head towards the core
//   instr_ready_i         core consumes the head
//   instr_err_o           head carries a fetch error (ERR_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | one cycle after reset, no requests
// FETCH | normal operation, requests issued while credits allow
// DRAIN | after a redirect, dropping responses still owed for the old path
// -----------------------------------------------------------------------------
module yarp_instr_fetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
`ifdef YARP_IFETCH_ERR_EN
  input  logic            mem_err_i,
  output logic            instr_err_o,
`endif
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  // In FETCH: requests granted but unanswered. In DRAIN: responses left to drop.
  logic [CW-1:0]   outst;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] buf_data [DEPTH];
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic [XLEN-1:0] pend_pc  [DEPTH];
  logic [AW-1:0]   pend_rd;
  logic [AW-1:0]   pend_wr;

  logic            fetch_stop;
`ifdef YARP_IFETCH_ERR_EN
  logic            buf_err  [DEPTH];
  logic            err_halt;
  assign fetch_stop = err_halt;
`else
  assign fetch_stop = 1'b0;
`endif

  logic          credit_ok;
  logic          grant;
  logic          pop;
  logic [CW-1:0] outst_upd;
  logic [CW-1:0] outst_flush;
  logic [CW-1:0] count_upd;

  // A response moves a credit from "outstanding" to "buffered" without
  // changing the sum, so once mem_req_o rises it can only fall through a
  // grant, a redirect or an error stop.
  assign credit_ok = (outst < MAX_W) &&
                     (({1'b0, outst} + {1'b0, count}) < DEPTH_W);

  assign mem_req_o  = (state == ST_FETCH) && credit_ok &&
                      !redirect_valid_i && !fetch_stop;
  assign mem_addr_o = fetch_pc;

  assign grant = mem_req_o & mem_gnt_i;
  assign pop   = instr_valid_o & instr_ready_i;

  assign outst_upd   = outst + CW'(grant) - CW'(mem_rvalid_i);
  assign outst_flush = outst - CW'(mem_rvalid_i);
  assign count_upd   = count + CW'(mem_rvalid_i) - CW'(pop);

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? buf_data[head] : '0;
  assign instr_pc_o    = instr_valid_o ? buf_pc[head]   : '0;
`ifdef YARP_IFETCH_ERR_EN
  assign instr_err_o   = instr_valid_o & buf_err[head];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      outst    <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      pend_rd  <= '0;
      pend_wr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
        pend_pc[i]  <= '0;
`ifdef YARP_IFETCH_ERR_EN
        buf_err[i]  <= 1'b0;
`endif
      end
`ifdef YARP_IFETCH_ERR_EN
      err_halt <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          if (redirect_valid_i) begin
            fetch_pc <= redirect_pc_i;
          end
        end

        ST_FETCH: begin
          if (redirect_valid_i) begin
            // Flush; a response arriving this cycle belongs to the old path
            // and is dropped, the rest are counted off in DRAIN.
            fetch_pc <= redirect_pc_i;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            pend_rd  <= '0;
            pend_wr  <= '0;
            outst    <= outst_flush;
            if (outst_flush != '0) begin
              state <= ST_DRAIN;
            end
`ifdef YARP_IFETCH_ERR_EN
            err_halt <= 1'b0;
`endif
          end else begin
            if (grant) begin
              fetch_pc         <= fetch_pc + XLEN'(4);
              pend_pc[pend_wr] <= fetch_pc;
              pend_wr          <= pend_wr + AW'(1);
            end
            if (mem_rvalid_i) begin
              buf_data[tail] <= mem_rdata_i;
              buf_pc[tail]   <= pend_pc[pend_rd];
              tail           <= tail + AW'(1);
              pend_rd        <= pend_rd + AW'(1);
`ifdef YARP_IFETCH_ERR_EN
              buf_err[tail]  <= mem_err_i;
              if (mem_err_i) begin
                err_halt <= 1'b1;
              end
`endif
            end
            if (pop) begin
              head <= head + AW'(1);
            end
            outst <= outst_upd;
            count <= count_upd;
          end
        end

        ST_DRAIN: begin
          if (redirect_valid_i) begin
            fetch_pc <= redirect_pc_i;
`ifdef YARP_IFETCH_ERR_EN
            err_halt <= 1'b0;
`endif
          end
          if (mem_rvalid_i) begin
            outst <= outst - CW'(1);
            if (outst == CW'(1)) begin
              state <= ST_FETCH;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
